fetch_pc_gen: RTL and testbench



---
 rtl/fetch_pkg.sv | 35 +++
 rtl/fetch_queue.sv | 71 +++++++
 rtl/fetch_pc_gen.sv | 155 +++++++++++++++
 tb/tb_fetch_pc_gen.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch-stage PC generator.
//   fetch_entry_t : one fetch-queue slot {pc, inst, pred_taken, pred_addr, filled}
//   fetch_state_t : top-level sequencing states {BOOT, RUN}
//   PC_STEP       : sequential PC increment in bytes
//   FQ_PTR        : index width of the fetch queue
// The entry struct is sized by the FETCH_* constants below, so the top's
// ADDR/INST/FQ_D parameters are expected to keep these default values.
package fetch_pkg;

  localparam int FETCH_ADDR = 32;
  localparam int FETCH_INST = 32;
  localparam int FETCH_FQ_D = 4;

  localparam int PC_STEP = FETCH_INST / 8;
  localparam int FQ_PTR  = $clog2(FETCH_FQ_D);

  typedef struct packed {
    logic [FETCH_ADDR-1:0] pc;
    logic [FETCH_INST-1:0] inst;
    logic                  pred_taken;
    logic [FETCH_ADDR-1:0] pred_addr;
    logic                  filled;
  } fetch_entry_t;

  typedef enum logic [0:0] {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

  // 32-bit counter increment that sticks at all-ones.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
    return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
  endfunction

endpackage

// File: rtl/fetch_queue.sv
// fetch_queue: in-order fetch buffer pairing each issued request with its
// I-cache response.
//   clk, reset              : clock, async active-high reset
//   clear                   : drop all entries (pointers back to zero)
//   push, push_pc/taken/tgt : allocate an unfilled entry at the tail
//   fill, fill_inst         : write the oldest unfilled entry
//   pop                     : retire the head entry
//   head                    : head entry contents
//   count, unfilled         : live entries / entries still awaiting data
// Three pointers carry one extra wrap bit: rd <= fl <= wr always holds,
// so the distances give count and unfilled directly.
import fetch_pkg::*;

module fetch_queue #(
  parameter int FQ_D = FETCH_FQ_D,
  localparam int PW  = $clog2(FQ_D)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clear,
  input  logic                  push,
  input  logic [FETCH_ADDR-1:0] push_pc,
  input  logic                  push_taken,
  input  logic [FETCH_ADDR-1:0] push_tgt,
  input  logic                  fill,
  input  logic [FETCH_INST-1:0] fill_inst,
  input  logic                  pop,
  output fetch_entry_t          head,
  output logic [PW:0]           count,
  output logic [PW:0]           unfilled
);

  fetch_entry_t mem [FQ_D];
  logic [PW:0]  wr_q, fl_q, rd_q;
  logic         push_ok, fill_ok, pop_ok;

  assign count    = wr_q - rd_q;
  assign unfilled = wr_q - fl_q;
  assign head     = mem[rd_q[PW-1:0]];

  // Guards keep the pointer ordering intact even if a caller misbehaves.
  assign push_ok = push && (count != (PW+1)'(FQ_D));
  assign fill_ok = fill && (unfilled != '0);
  assign pop_ok  = pop && (count != '0) && head.filled;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_q <= '0;
      fl_q <= '0;
      rd_q <= '0;
      for (int i = 0; i < FQ_D; i++) mem[i] <= '0;
    end else if (clear) begin
      wr_q <= '0;
      fl_q <= '0;
      rd_q <= '0;
    end else begin
      if (push_ok) begin
        mem[wr_q[PW-1:0]] <= '{pc: push_pc, inst: '0, pred_taken: push_taken,
                               pred_addr: push_tgt, filled: 1'b0};
        wr_q <= wr_q + 1'b1;
      end
      if (fill_ok) begin
        mem[fl_q[PW-1:0]].inst   <= fill_inst;
        mem[fl_q[PW-1:0]].filled <= 1'b1;
        fl_q <= fl_q + 1'b1;
      end
      if (pop_ok) rd_q <= rd_q + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_pc_gen.sv
// fetch_pc_gen: next-PC selection, I-cache request issue and fetch buffer.
//   clk, reset                      : clock, async active-high reset
//   btb_pc / btb_hit / btb_addr     : BTB lookup of the current fetch PC
//   redirect_ / redirect_addr       : active-low commit-side restart
//   ic_req_ / ic_addr / ic_ready    : active-low I-cache request handshake
//   ic_resp_ / ic_inst              : active-low in-order response strobe
//   fd_valid_ / fd_pc / fd_inst     : active-low decode output
//   fd_pred_taken_ / fd_pred_addr   : prediction attached to the output
//   fd_stall                        : decode backpressure
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters
// perf_fetch, perf_btb_taken, perf_redirect, perf_drop.
//
// state | meaning
// BOOT  | first cycle out of reset, no request issued
// RUN   | normal fetch
import fetch_pkg::*;

module fetch_pc_gen #(
  parameter int              ADDR      = FETCH_ADDR,
  parameter int              INST      = FETCH_INST,
  parameter int              FQ_D      = FETCH_FQ_D,
  parameter logic [ADDR-1:0] RESET_VEC = '0
) (
  input  logic            clk,
  input  logic            reset,
  output logic [ADDR-1:0] btb_pc,
  input  logic            btb_hit,
  input  logic [ADDR-1:0] btb_addr,
  input  logic            redirect_,
  input  logic [ADDR-1:0] redirect_addr,
  output logic            ic_req_,
  output logic [ADDR-1:0] ic_addr,
  input  logic            ic_ready,
  input  logic            ic_resp_,
  input  logic [INST-1:0] ic_inst,
  output logic            fd_valid_,
  output logic [ADDR-1:0] fd_pc,
  output logic [INST-1:0] fd_inst,
  output logic            fd_pred_taken_,
  output logic [ADDR-1:0] fd_pred_addr,
  input  logic            fd_stall
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetch,
  output logic [31:0]     perf_btb_taken,
  output logic [31:0]     perf_redirect,
  output logic [31:0]     perf_drop
`endif
);

  localparam int PW = $clog2(FQ_D);

  localparam logic [0:0] ST_BOOT = 1'(BOOT);
  localparam logic [0:0] ST_RUN  = 1'(RUN);

  logic [0:0]      state_q;
  logic [ADDR-1:0] pc_q;
  logic [PW:0]     drop_q, drop_d;
  logic [PW:0]     cnt, unfilled;
  logic [PW+1:0]   occ;
  fetch_entry_t    head;

  logic            redirect, resp, resp_fill, resp_drop;
  logic            can_issue, accept, out_valid, pop;
  logic [ADDR-1:0] pred_tgt;

  assign redirect  = !redirect_;
  assign resp      = !ic_resp_;
  assign resp_drop = resp && (drop_q != '0);
  assign resp_fill = resp && (drop_q == '0);

  // Dropped-but-outstanding responses still occupy cache slots, so they
  // count against the request cap alongside live entries.
  assign occ       = {1'b0, cnt} + {1'b0, drop_q};
  assign can_issue = (state_q == ST_RUN) && (occ < (PW+2)'(FQ_D)) && !redirect;
  assign accept    = can_issue && ic_ready;
  assign pred_tgt  = btb_hit ? btb_addr : pc_q + ADDR'(PC_STEP);

  assign out_valid = (cnt != '0) && head.filled && !redirect;
  assign pop       = out_valid && !fd_stall;

  assign btb_pc  = pc_q;
  assign ic_addr = pc_q;
  assign ic_req_ = !can_issue;

  assign fd_valid_      = !out_valid;
  assign fd_pc          = out_valid ? head.pc        : '0;
  assign fd_inst        = out_valid ? head.inst      : '0;
  assign fd_pred_addr   = out_valid ? head.pred_addr : '0;
  assign fd_pred_taken_ = !(out_valid && head.pred_taken);

  // On redirect every unfilled entry becomes a response to throw away.
  // The sum never exceeds FQ_D, so modular PW+1 bit arithmetic is exact.
  always_comb begin
    drop_d = drop_q;
    if (redirect)
      drop_d = drop_q + unfilled + {{PW{1'b0}}, accept} - {{PW{1'b0}}, resp};
    else if (resp_drop)
      drop_d = drop_q - 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_BOOT;
      pc_q    <= RESET_VEC;
      drop_q  <= '0;
    end else begin
      case (state_q)
        ST_BOOT: state_q <= ST_RUN;
        default: state_q <= ST_RUN;
      endcase
      drop_q <= drop_d;
      if (redirect)
        pc_q <= redirect_addr;
      else if (accept)
        pc_q <= pred_tgt;
    end
  end

  fetch_queue #(.FQ_D(FQ_D)) u_queue (
    .clk        (clk),
    .reset      (reset),
    .clear      (redirect),
    .push       (accept && !redirect),
    .push_pc    (pc_q),
    .push_taken (btb_hit),
    .push_tgt   (pred_tgt),
    .fill       (resp_fill && !redirect),
    .fill_inst  (ic_inst),
    .pop        (pop),
    .head       (head),
    .count      (cnt),
    .unfilled   (unfilled)
  );

  a_no_orphan_resp: assert property (
    @(posedge clk) disable iff (reset) resp |-> ((drop_q != '0) || (unfilled != '0)));

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetch     <= '0;
      perf_btb_taken <= '0;
      perf_redirect  <= '0;
      perf_drop      <= '0;
    end else begin
      perf_fetch     <= sat_inc(perf_fetch, accept);
      perf_btb_taken <= sat_inc(perf_btb_taken, accept && btb_hit);
      perf_redirect  <= sat_inc(perf_redirect, redirect);
      perf_drop      <= sat_inc(perf_drop, resp_drop);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_pc_gen.sv
// tb_fetch_pc_gen: scoreboard bench for fetch_pc_gen. A small cache model
// answers accepted requests in order (inst = ~addr), a PC model predicts
// each request address, and expected decode entries are queued at accept
// and compared when decode pops them.
module tb_fetch_pc_gen;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] btb_pc, btb_addr, redirect_addr, ic_addr, fd_pc, fd_pred_addr;
  logic [31:0] ic_inst, fd_inst;
  logic        btb_hit, redirect_, ic_req_, ic_ready, ic_resp_;
  logic        fd_valid_, fd_pred_taken_, fd_stall;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetch, perf_btb_taken, perf_redirect, perf_drop;
`endif

  always #5 clk = ~clk;

  fetch_pc_gen dut (
    .clk            (clk),
    .reset          (reset),
    .btb_pc         (btb_pc),
    .btb_hit        (btb_hit),
    .btb_addr       (btb_addr),
    .redirect_      (redirect_),
    .redirect_addr  (redirect_addr),
    .ic_req_        (ic_req_),
    .ic_addr        (ic_addr),
    .ic_ready       (ic_ready),
    .ic_resp_       (ic_resp_),
    .ic_inst        (ic_inst),
    .fd_valid_      (fd_valid_),
    .fd_pc          (fd_pc),
    .fd_inst        (fd_inst),
    .fd_pred_taken_ (fd_pred_taken_),
    .fd_pred_addr   (fd_pred_addr),
    .fd_stall       (fd_stall)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetch     (perf_fetch),
    .perf_btb_taken (perf_btb_taken),
    .perf_redirect  (perf_redirect),
    .perf_drop      (perf_drop)
`endif
  );

  typedef struct {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        taken;
    logic [31:0] tgt;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        exp_q[$];
  pend_t       pend_q[$];
  logic [31:0] acc_log[$];

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int acc_cnt = 0;
  int acc_limit = 1000000;
  int pop_cnt = 0;

  logic [31:0] model_pc;
  bit          btb_en;
  logic [31:0] btb_key, btb_tgt;
  bit          resp_hold;
  logic        redir_drv;
  logic [31:0] redir_addr_drv;
  logic        stall_drv;
  bit          watch_first;
  logic [31:0] first_pop_pc;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic idle_inputs();
    btb_hit       = 1'b0;
    btb_addr      = '0;
    redirect_     = 1'b1;
    redirect_addr = '0;
    ic_ready      = 1'b0;
    ic_resp_      = 1'b1;
    ic_inst       = '0;
    fd_stall      = 1'b0;
  endtask

  // One clock: drive at negedge, evaluate 1 time unit later, edge follows.
  task automatic cycle();
    bit accept;
    @(negedge clk);
    btb_hit       = btb_en && (btb_pc == btb_key);
    btb_addr      = btb_tgt;
    redirect_     = redir_drv;
    redirect_addr = redir_addr_drv;
    fd_stall      = stall_drv;
    ic_ready      = (acc_cnt < acc_limit);
    if (!resp_hold && pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      ic_resp_ = 1'b0;
      ic_inst  = ~pend_q[0].addr;
      void'(pend_q.pop_front());
    end else begin
      ic_resp_ = 1'b1;
      ic_inst  = '0;
    end
    #1;
    if (!fd_valid_ && !fd_stall) begin
      pop_cnt++;
      if (exp_q.size() == 0) begin
        chk("fd_valid_ with nothing expected", fd_valid_, 1'b1);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fd_pc", fd_pc, e.pc);
        chk("fd_inst", fd_inst, e.inst);
        chk("fd_pred_taken_", fd_pred_taken_, !e.taken);
        chk("fd_pred_addr", fd_pred_addr, e.tgt);
        if (watch_first) begin
          first_pop_pc = fd_pc;
          watch_first  = 1'b0;
        end
      end
    end
    if (!redirect_) begin
      chk("redirect fd_valid_", fd_valid_, 1'b1);
      chk("redirect ic_req_", ic_req_, 1'b1);
    end
    accept = !ic_req_ && ic_ready;
    if (accept) begin
      exp_t  e;
      pend_t p;
      chk("ic_addr", ic_addr, model_pc);
      e.pc    = model_pc;
      e.inst  = ~model_pc;
      e.taken = btb_hit;
      e.tgt   = btb_hit ? btb_addr : model_pc + 32'd4;
      exp_q.push_back(e);
      p.addr = model_pc;
      p.due  = cyc + 2;
      pend_q.push_back(p);
      acc_log.push_back(model_pc);
      acc_cnt++;
      model_pc = e.tgt;
    end
    if (!redirect_) begin
      model_pc = redirect_addr;
      exp_q.delete();
    end
    cyc++;
  endtask

  // Asynchronous reset mid-cycle; outputs must change without a clock edge.
  task automatic do_reset();
    @(negedge clk);
    idle_inputs();
    #2;
    reset = 1'b1;
    #1;
    chk("rst ic_req_", ic_req_, 1'b1);
    chk("rst fd_valid_", fd_valid_, 1'b1);
    chk("rst fd_pred_taken_", fd_pred_taken_, 1'b1);
    chk("rst fd_pc", fd_pc, 32'h0);
    chk("rst fd_inst", fd_inst, 32'h0);
    chk("rst fd_pred_addr", fd_pred_addr, 32'h0);
    chk("rst ic_addr", ic_addr, 32'h0);
    chk("rst btb_pc", btb_pc, 32'h0);
    pend_q.delete();
    exp_q.delete();
    acc_log.delete();
    model_pc       = 32'h0;
    acc_cnt        = 0;
    acc_limit      = 1000000;
    btb_en         = 1'b0;
    btb_key        = '0;
    btb_tgt        = '0;
    resp_hold      = 1'b0;
    redir_drv      = 1'b1;
    redir_addr_drv = '0;
    stall_drv      = 1'b0;
    watch_first    = 1'b0;
    first_pop_pc   = 32'hDEAD_BEEF;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    chk("boot ic_req_", ic_req_, 1'b1);
  endtask

  task automatic drain(input string tag);
    acc_limit = acc_cnt;
    stall_drv = 1'b0;
    repeat (12) cycle();
    chk({tag, " leftover expected"}, exp_q.size(), 0);
    chk({tag, " drained fd_valid_"}, fd_valid_, 1'b1);
  endtask

  initial begin
    int pops0;
    reset = 1'b1;
    idle_inputs();

    // Sequential fetch, no prediction.
    do_reset();
    repeat (20) cycle();
    chk("seq req0", acc_log[0], 32'h0);
    chk("seq req1", acc_log[1], 32'h4);
    chk("seq req2", acc_log[2], 32'h8);
    chk("seq req3", acc_log[3], 32'hC);
    chk("seq popped some", pop_cnt >= 4, 1'b1);
    drain("seq");

    // BTB hit at 0x8 steers to 0x100.
    do_reset();
    btb_en  = 1'b1;
    btb_key = 32'h8;
    btb_tgt = 32'h100;
    repeat (20) cycle();
    chk("btb req after 0x8", acc_log[3], 32'h100);
    chk("btb req after 0x100", acc_log[4], 32'h104);
    drain("btb");

    // Decode stalled: queue fills to FQ_D and issue stops.
    do_reset();
    stall_drv = 1'b1;
    repeat (12) cycle();
    chk("stall accepts", acc_cnt, 4);
    chk("stall ic_req_", ic_req_, 1'b1);
    chk("stall fd_valid_", fd_valid_, 1'b0);
    pops0 = pop_cnt;
    drain("stall");
    chk("stall drained entries", pop_cnt - pops0, 4);

    // Redirect with three unfilled requests, no response that cycle.
    do_reset();
    resp_hold = 1'b1;
    acc_limit = 3;
    repeat (5) cycle();
    chk("redir3 accepts", acc_cnt, 3);
    redir_drv      = 1'b0;
    redir_addr_drv = 32'h200;
    cycle();
    redir_drv   = 1'b1;
    resp_hold   = 1'b0;
    acc_limit   = 1000000;
    watch_first = 1'b1;
    repeat (25) cycle();
    chk("redir3 first pc", first_pop_pc, 32'h200);
    drain("redir3");

    // Redirect in the same cycle as a response, three unfilled.
    do_reset();
    resp_hold = 1'b1;
    acc_limit = 3;
    repeat (5) cycle();
    resp_hold      = 1'b0;
    redir_drv      = 1'b0;
    redir_addr_drv = 32'h200;
    cycle();
    redir_drv = 1'b1;
    acc_limit = 1000000;
    watch_first = 1'b1;
    cycle();
    chk("redir+resp ic_addr", acc_log[3], 32'h200);
    repeat (20) cycle();
    chk("redir+resp first pc", first_pop_pc, 32'h200);
    drain("redir+resp");

    // Reset while holding two entries and one pending drop.
    do_reset();
    resp_hold = 1'b1;
    acc_limit = 1;
    repeat (3) cycle();
    redir_drv      = 1'b0;
    redir_addr_drv = 32'h300;
    cycle();
    redir_drv = 1'b1;
    acc_limit = 3;
    repeat (4) cycle();
    chk("pre-reset ic_req_", ic_req_, 1'b0);
    chk("pre-reset ic_addr", ic_addr, 32'h308);
    do_reset();
    repeat (15) cycle();
    chk("post-reset req0", acc_log[0], 32'h0);
    chk("post-reset req1", acc_log[1], 32'h4);
    drain("post-reset");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
